// File: rtl/tail_input_conditioner.sv
// -----------------------------------------------------------------------------
// tail_input_conditioner
//
// Input stage of the tail-light controller. The raw board controls pass
// through a two-flop synchronizer and a per-channel debounce counter. The
// clean levels are then resolved into one registered request mode. A one-cycle
// mode_change pulse marks every cycle in which mode takes a new value, and
// downstream logic uses it to restart the blink counter.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   SW[2:0]      in   raw switches: [0] hazard, [1] left, [2] brake (active-high)
//   KEY          in   raw right-turn push-button (active-low)
//   hazard_clean out  debounced SW[0]
//   left_clean   out  debounced SW[1]
//   brake_clean  out  debounced SW[2]
//   right_clean  out  debounced, inverted KEY (1 = pressed)
//   mode[2:0]    out  registered request: 0 IDLE, 1 HAZARD, 2 LEFT, 3 RIGHT,
//                     4 BRAKE, 5 BRAKE_LEFT, 6 BRAKE_RIGHT
//   mode_change  out  one-cycle pulse when mode takes a new value
// -----------------------------------------------------------------------------
module tail_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] SW,
  input  logic       KEY,
  output logic       hazard_clean,
  output logic       left_clean,
  output logic       brake_clean,
  output logic       right_clean,
  output logic [2:0] mode,
  output logic       mode_change
);

  typedef enum logic [2:0] {
    MODE_IDLE        = 3'd0,
    MODE_HAZARD      = 3'd1,
    MODE_LEFT        = 3'd2,
    MODE_RIGHT       = 3'd3,
    MODE_BRAKE       = 3'd4,
    MODE_BRAKE_LEFT  = 3'd5,
    MODE_BRAKE_RIGHT = 3'd6
  } mode_e;

  // Channel order everywhere: 0 hazard, 1 left, 2 brake, 3 right.
  // The synchronizer carries KEY in its raw active-low form, so its idle
  // reset value is 1 for that channel.
  localparam logic [3:0]       SYNC_RST = 4'b1000;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]            raw;
  logic [3:0]            sync1_q, sync1_d;
  logic [3:0]            sync2_q, sync2_d;
  logic [3:0]            level;             // synchronized, all active-high
  logic [3:0]            clean_q, clean_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  mode_e                 mode_q, mode_d;
  logic                  mode_change_q, mode_change_d;

  assign raw = {KEY, SW};

  // Synchronizer and debounce.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    sync1_d = raw;
    sync2_d = sync1_q;
    level   = {~sync2_q[3], sync2_q[2:0]};
    clean_d = clean_q;
    cnt_d   = cnt_q;
    for (int ch = 0; ch < 4; ch++) begin
      if (level[ch] == clean_q[ch]) begin
        // Agreement (including a bounce back) restarts the count.
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_MAX) begin
        clean_d[ch] = level[ch];
        cnt_d[ch]   = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + 1'b1;
      end
    end
  end

  // Mode resolution from the clean levels, in strict priority order.
  always_comb begin
    mode_d = MODE_IDLE;
    if (clean_q[0])                    mode_d = MODE_HAZARD;
    else if (clean_q[1] && clean_q[3]) mode_d = MODE_HAZARD;
    else if (clean_q[2] && clean_q[1]) mode_d = MODE_BRAKE_LEFT;
    else if (clean_q[2] && clean_q[3]) mode_d = MODE_BRAKE_RIGHT;
    else if (clean_q[2])               mode_d = MODE_BRAKE;
    else if (clean_q[1])               mode_d = MODE_LEFT;
    else if (clean_q[3])               mode_d = MODE_RIGHT;
    mode_change_d = (mode_d != mode_q);
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q       <= SYNC_RST;
      sync2_q       <= SYNC_RST;
      clean_q       <= '0;
      cnt_q         <= '0;
      mode_q        <= MODE_IDLE;
      mode_change_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      clean_q       <= clean_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      mode_change_q <= mode_change_d;
    end
  end

  assign hazard_clean = clean_q[0];
  assign left_clean   = clean_q[1];
  assign brake_clean  = clean_q[2];
  assign right_clean  = clean_q[3];
  assign mode         = mode_q;
  assign mode_change  = mode_change_q;

endmodule

// File: tb/tb_tail_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_tail_input_conditioner
//
// Directed scenarios followed by randomized input sequences. The reference
// model keeps a sliding window of the last D synchronized samples per channel.
// A clean level flips once all D samples in the window disagree with it. Mode
// comes from a plain priority function. Every cycle compares all clean
// outputs, mode and mode_change against the model. Directed latency and pulse
// checks use fixed expected numbers.
// -----------------------------------------------------------------------------
module tb_tail_input_conditioner;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] SW    = 3'b000;
  logic       KEY   = 1'b1;
  logic       hazard_clean, left_clean, brake_clean, right_clean;
  logic [2:0] mode;
  logic       mode_change;

  tail_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .SW           (SW),
    .KEY          (KEY),
    .hazard_clean (hazard_clean),
    .left_clean   (left_clean),
    .brake_clean  (brake_clean),
    .right_clean  (right_clean),
    .mode         (mode),
    .mode_change  (mode_change)
  );

  always #10 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int mc_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_s1 = 4'b1000, m_s2 = 4'b1000;
  bit   [3:0] m_clean = '0;
  int         m_mode = 0;
  bit         m_mc = 0;
  bit         hist[4][$];

  function automatic int resolve(input bit [3:0] c);
    bit h, l, b, r;
    h = c[0]; l = c[1]; b = c[2]; r = c[3];
    if (h)      return 1;
    if (l && r) return 1;
    if (b && l) return 5;
    if (b && r) return 6;
    if (b)      return 4;
    if (l)      return 2;
    if (r)      return 3;
    return 0;
  endfunction

  task automatic model_step(input logic rst, input logic [3:0] raw);
    bit [3:0] lvl;
    int       nm;
    bit       all_diff;
    if (rst) begin
      m_s1 = 4'b1000; m_s2 = 4'b1000; m_clean = '0; m_mode = 0; m_mc = 0;
      for (int ch = 0; ch < 4; ch++) hist[ch].delete();
    end else begin
      lvl  = {~m_s2[3], m_s2[2:0]};
      nm   = resolve(m_clean);
      m_mc = (nm != m_mode);
      m_mode = nm;
      for (int ch = 0; ch < 4; ch++) begin
        hist[ch].push_back(lvl[ch]);
        if (hist[ch].size() > D) void'(hist[ch].pop_front());
        if (hist[ch].size() == D) begin
          all_diff = 1;
          foreach (hist[ch][i]) if (hist[ch][i] == m_clean[ch]) all_diff = 0;
          if (all_diff) m_clean[ch] = lvl[ch];
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  // One clock edge: advance the model, then compare just after the edge.
  task automatic tick();
    @(posedge clock);
    model_step(reset, {KEY, SW});
    #1;
    check("hazard_clean", hazard_clean, m_clean[0]);
    check("left_clean",   left_clean,   m_clean[1]);
    check("brake_clean",  brake_clean,  m_clean[2]);
    check("right_clean",  right_clean,  m_clean[3]);
    check("mode",         mode,         m_mode);
    check("mode_change",  mode_change,  m_mc);
    if (mode_change === 1'b1) mc_count++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // The caller has just applied a change on channel ch; the next edge samples
  // it. Checks the edge offset of the clean rise, then a one-cycle pulse.
  task automatic expect_rise(input string tag, input int ch, input int exp_edges);
    logic [3:0] cl;
    bit         mc_hist[20];
    int         n;
    n = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      cl = {right_clean, brake_clean, left_clean, hazard_clean};
      mc_hist[i] = mode_change;
      if (cl[ch] === 1'b1 && n < 0) n = i;
    end
    check({tag, "_rise_edge"}, n, exp_edges);
    if (n >= 0 && n + 2 < 20) begin
      check({tag, "_mc_pulse"}, mc_hist[n + 1], 1);
      check({tag, "_mc_end"},   mc_hist[n + 2], 0);
    end
  endtask

  int mc0;
  bit left_seen;

  initial begin
    // Reset and idle.
    reset = 1'b1; SW = 3'b000; KEY = 1'b1;
    ticks(2);
    reset = 1'b0;
    mc0 = mc_count;
    ticks(10);
    check("idle_mode", mode, 0);
    check("idle_no_pulse", mc_count - mc0, 0);

    // Hazard latency.
    SW[0] = 1'b1;
    expect_rise("hazard", 0, D + 1);
    check("hazard_mode", mode, 1);
    SW[0] = 1'b0;
    ticks(10);

    // Short glitch on left never propagates.
    mc0 = mc_count; left_seen = 0;
    SW[1] = 1'b1;
    for (int i = 0; i < D - 1; i++) begin tick(); if (left_clean) left_seen = 1; end
    SW[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (left_clean) left_seen = 1; end
    check("glitch_left", left_seen, 0);
    check("glitch_no_pulse", mc_count - mc0, 0);

    // Pulse of exactly D cycles does propagate.
    left_seen = 0;
    SW[1] = 1'b1;
    for (int i = 0; i < D; i++) begin tick(); if (left_clean) left_seen = 1; end
    SW[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (left_clean) left_seen = 1; end
    check("pulse_left", left_seen, 1);

    // LEFT -> BRAKE_LEFT -> BRAKE_RIGHT with single pulses.
    SW[1] = 1'b1;
    ticks(10);
    check("left_mode", mode, 2);
    mc0 = mc_count;
    SW[2] = 1'b1;
    ticks(10);
    check("brake_left_mode", mode, 5);
    check("brake_left_pulses", mc_count - mc0, 1);
    mc0 = mc_count;
    KEY = 1'b0; SW[1] = 1'b0;
    ticks(10);
    check("brake_right_mode", mode, 6);
    check("brake_right_pulses", mc_count - mc0, 1);

    // Bounce on brake, then hold.
    SW = 3'b000; KEY = 1'b1;
    ticks(10);
    for (int i = 0; i < 2; i++) begin
      SW[2] = 1'b1; tick();
      SW[2] = 1'b0; tick();
    end
    SW[2] = 1'b1;
    expect_rise("bounce", 2, D + 1);

    // Reset in the middle of a pending hazard count.
    SW = 3'b000;
    ticks(10);
    SW[0] = 1'b1;
    ticks(2);
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    expect_rise("reset_mid", 0, D + 1);

    // Randomized sequences.
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 99) < 2) begin
        reset = 1'b1;
        ticks($urandom_range(1, 2));
        reset = 1'b0;
      end
      if ($urandom_range(0, 9) < 7) begin
        int b;
        b = $urandom_range(0, 3);
        if (b == 3) KEY = ~KEY;
        else        SW[b] = ~SW[b];
      end else begin
        SW  = 3'($urandom);
        KEY = 1'($urandom);
      end
      ticks($urandom_range(1, 2 * D));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
